func_share_arbiter: RTL

Sequencer that shares one start/ready function unit (e.g. a three-operand 16-bit recursive-function unit with ST/RD handshake) among NREQ requesters. Each requester issues a one-cycle ST pulse with its operands. The arbiter queues the request, grants requesters in round-robin order, launches the unit, and returns the result with a one-cycle per-requester RD pulse. It sits between the functional units and the blocks that compose them, so one costly unit can serve several call sites.

---
 rtl/func_arb_pkg.sv | 25 ++
 rtl/rr_pick.sv | 38 +++
 rtl/func_share_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/func_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : func_arb_pkg
// Brief    : Shared types and defaults for the function-unit share arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package func_arb_pkg;

    localparam int c_BW_DEFAULT      = 16;
    localparam int c_TIMEOUT_DEFAULT = 1024;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Index width for a requester count; never zero so single-bit ports stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first pending bit after last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import func_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] i_pending,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IW-1:0]   o_idx
);

    always_comb begin
        logic          w_found;
        logic [IW-1:0] w_j;
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = '0;
        // Searching last+1 .. last+NREQ visits last itself at the very end.
        for (int k = 1; k <= NREQ; k++) begin
            w_j = IW'((int'(i_last) + k) % NREQ);
            if (!w_found && i_pending[w_j]) begin
                w_found    = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx      = w_j;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/func_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : func_share_arbiter
// Brief    : Queues ST requests from NREQ callers and serves them round-robin
//            on one shared start/ready function unit.
//            Optional watchdog: define FUNC_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module func_share_arbiter
    import func_arb_pkg::*;
#(
    parameter int BW      = c_BW_DEFAULT,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ_ST,
    input  logic [NREQ*BW-1:0] REQ_IN0,
    input  logic [NREQ*BW-1:0] REQ_IN1,
    input  logic [NREQ*BW-1:0] REQ_IN2,
    output logic [NREQ-1:0] REQ_RD,
    output logic [BW-1:0]   RES,
    output logic            ERR,
    output logic            BUSY,
    output logic            U_RST,
    output logic            U_ST,
    output logic [BW-1:0]   U_IN0,
    output logic [BW-1:0]   U_IN1,
    output logic [BW-1:0]   U_IN2,
    input  logic            U_RD,
    input  logic [BW-1:0]   U_RES
);

    localparam int c_IW = idx_width(NREQ);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NREQ-1:0]   r_pending;
    logic [BW-1:0]     r_opnd0 [NREQ];
    logic [BW-1:0]     r_opnd1 [NREQ];
    logic [BW-1:0]     r_opnd2 [NREQ];
    logic [c_IW-1:0]   r_last;
    logic [NREQ-1:0]   r_gnt_oh;
    logic [BW-1:0]     r_uin0;
    logic [BW-1:0]     r_uin1;
    logic [BW-1:0]     r_uin2;
    logic [BW-1:0]     r_res;

    logic [NREQ-1:0]   w_new;
    logic [NREQ-1:0]   w_clr;
    logic [NREQ-1:0]   w_gnt_oh;
    logic [c_IW-1:0]   w_gnt_idx;
    logic              w_go;
    logic              w_done_ok;
    logic              w_done_to;
    logic              w_expire;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (c_IW)
    ) u_rr_pick (
        .i_pending (r_pending),
        .i_last    (r_last),
        .o_grant   (w_gnt_oh),
        .o_idx     (w_gnt_idx)
    );

    // A pulse from a requester that is already pending is dropped entirely.
    assign w_new = REQ_ST & ~r_pending;
    assign w_clr = w_go ? w_gnt_oh : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_new;
        end
    end

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_opnd
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_opnd0[i] <= '0;
                    r_opnd1[i] <= '0;
                    r_opnd2[i] <= '0;
                end else if (w_new[i]) begin
                    r_opnd0[i] <= REQ_IN0[i*BW +: BW];
                    r_opnd1[i] <= REQ_IN1[i*BW +: BW];
                    r_opnd2[i] <= REQ_IN2[i*BW +: BW];
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_done_ok   = 1'b0;
        w_done_to   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) begin
                    w_go        = 1'b1;
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_nxt = S_WAIT;
            S_WAIT: begin
                // A done pulse coinciding with watchdog expiry counts as success.
                if (U_RD) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_expire) begin
                    w_done_to   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last   <= c_IW'(NREQ - 1);
            r_gnt_oh <= '0;
            r_uin0   <= '0;
            r_uin1   <= '0;
            r_uin2   <= '0;
            r_res    <= '0;
        end else begin
            if (w_go) begin
                r_last   <= w_gnt_idx;
                r_gnt_oh <= w_gnt_oh;
                r_uin0   <= r_opnd0[w_gnt_idx];
                r_uin1   <= r_opnd1[w_gnt_idx];
                r_uin2   <= r_opnd2[w_gnt_idx];
            end
            if (w_done_ok) begin
                r_res <= U_RES;
            end else if (w_done_to) begin
                r_res <= '0;
            end
        end
    end

`ifdef FUNC_ARB_TIMEOUT_EN
    localparam int c_WW = $clog2(TIMEOUT + 1);

    logic [c_WW-1:0] r_wdog;
    logic            r_err;

    always_ff @(posedge CLK) begin
        if (RST || (r_state != S_WAIT)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_expire = (r_state == S_WAIT) && (r_wdog == c_WW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_done_ok || w_go) begin
            r_err <= 1'b0;
        end else if (w_done_to) begin
            r_err <= 1'b1;
        end
    end

    assign ERR   = (r_state == S_DONE) && r_err;
    // Flushing the unit on a timed-out completion keeps a late U_RD from landing on the next grant.
    assign U_RST = RST || ERR;
`else
    assign w_expire = 1'b0;
    assign ERR      = 1'b0;
    assign U_RST    = RST;
`endif

    assign REQ_RD = (r_state == S_DONE) ? r_gnt_oh : '0;
    assign RES    = r_res;
    assign BUSY   = (r_state != S_IDLE);
    assign U_ST   = (r_state == S_LAUNCH);
    assign U_IN0  = r_uin0;
    assign U_IN1  = r_uin1;
    assign U_IN2  = r_uin2;

endmodule
`default_nettype wire
